spi_master: RTL

- SPI initiator for the team's SPI memory slave; host-side block issuing single-byte read/write transactions.
- Frame: command byte {addr[6:0], rw} then one data byte, both MSB first. rw=1 is read, rw=0 is write.
- SPI mode 0: SCLK idles low; MOSI changes while SCLK is low; the slave samples on the SCLK rising edge and updates MISO after the falling edge.
- Sits between a host/test controller and the pins that feed the slave's input conditioners.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_bit_timer.sv | 55 +++++
 rtl/spi_master.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator and its bit timer.
package spi_pkg;

  // Transaction sequencer states. Encodings are fixed so a checker or a
  // waveform viewer can decode the raw value.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CS_SETUP   = 3'd1,
    SHIFT_CMD  = 3'd2,
    GAP        = 3'd3,
    SHIFT_DATA = 3'd4,
    CS_HOLD    = 3'd5
  } state_e;

  // Direction bit carried in the LSB of the command byte.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bits per byte on the wire (command and data bytes alike).
  localparam int FRAME_BITS = 8;

  // Larger of two integers; used to size the shared cycle counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Half-period timer for the SPI clock. While enabled it alternates a low
// and a high phase of CLK_DIV cycles each and counts bits within a byte.
// The strobes mark the clk edge that ends each phase.
module spi_bit_timer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,       // count while in a shift state
  input  logic clear,        // return to start of a low phase, bit 0
  output logic phase,        // 0 = low half, 1 = high half (drives sclk)
  output logic rise_strobe,  // this edge drives sclk 0->1
  output logic fall_strobe,  // this edge drives sclk 1->0 (end of bit)
  output logic bit_last      // current bit is the last of the byte
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'(FRAME_BITS - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic             half_end;

  assign half_end    = enable && (div_cnt == DIV_LAST);
  assign rise_strobe = half_end && !phase;
  assign fall_strobe = half_end && phase;
  assign bit_last    = (bit_cnt == BIT_LAST);

  // Phase / half-period / bit counting; bit counter wraps 7->0 per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (clear) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (enable) begin
      if (half_end) begin
        div_cnt <= '0;
        phase   <= ~phase;
        if (phase) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator issuing one command byte {addr, rw} followed by one
// data byte, both MSB first. Writes send wdata; reads send zeros and keep
// the eight MISO samples of the data byte.
//
// Host handshake: start is a request sampled only in IDLE; the transaction
// it launches is marked by busy, and done pulses for exactly one cycle on
// the edge that ends it. A start held high in the done cycle is accepted.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int GAP_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int               CNT_W    = $clog2(max_int(CLK_DIV, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  state_e           state;
  logic [CNT_W-1:0] cnt;       // CS_SETUP / GAP / CS_HOLD cycle counter
  logic [7:0]       tx_sr;     // outgoing byte, MSB is on mosi
  logic [7:0]       rx_sr;     // incoming MISO samples, LSB newest
  logic [7:0]       wdata_q;
  logic             rw_q;
  logic [7:0]       data_byte; // byte sent in the data phase

  logic shifting;
  logic phase;
  logic rise_strobe;
  logic fall_strobe;
  logic bit_last;

  // A read clocks out zeros during the data byte.
  assign data_byte = (rw_q == RW_READ) ? 8'h00 : wdata_q;
  assign shifting  = (state == SHIFT_CMD) || (state == SHIFT_DATA);

  // sclk is the timer phase register, so it is glitch-free and low
  // whenever the timer is cleared or reset.
  assign sclk = phase;

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (shifting),
    .clear       (!shifting),
    .phase       (phase),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe),
    .bit_last    (bit_last)
  );

  // Transaction sequencer: owns cs_n, mosi, busy, done and rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_sr   <= 8'h00;
      rx_sr   <= 8'h00;
      wdata_q <= 8'h00;
      rw_q    <= RW_WRITE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= {addr, rw};
            wdata_q <= wdata;
            rw_q    <= rw;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            mosi    <= addr[6];  // command bit 7 is driven through CS_SETUP
            cnt     <= '0;
            state   <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= SHIFT_CMD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT_CMD: begin
          if (fall_strobe) begin
            if (bit_last) begin
              // First data bit is presented as soon as the command ends so
              // it is already stable through the gap.
              tx_sr <= data_byte;
              mosi  <= data_byte[7];
              cnt   <= '0;
              state <= HAS_GAP ? GAP : SHIFT_DATA;
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              mosi  <= tx_sr[6];
            end
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHIFT_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT_DATA: begin
          if (rise_strobe && (rw_q == RW_READ)) begin
            rx_sr <= {rx_sr[6:0], miso};
          end
          if (fall_strobe) begin
            if (bit_last) begin
              mosi  <= 1'b0;
              cnt   <= '0;
              state <= CS_HOLD;
            end else begin
              tx_sr <= {tx_sr[6:0], 1'b0};
              mosi  <= tx_sr[6];
            end
          end
        end

        CS_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            mosi  <= 1'b0;
            done  <= 1'b1;
            if (rw_q == RW_READ) begin
              rdata <= rx_sr;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
